id_issue_stage: RTL

Parametrised decode/issue stage that holds one decoded instruction, collects up to NUM_SRC register operands from an internal register file or from NUM_BYP younger pipeline stages, and stalls on unresolved hazards. It resolves branches in the issue cycle and emits a one-cycle redirect on a misprediction. It sits between the pre-decode stage and EXE, with a valid/ready handshake on both sides.

---
 rtl/id_issue_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/id_issue_stage.sv
// Decode/issue stage: one-entry holding register, operand collection (regfile + bypass), branch resolve.
// Optional macro ID_BYPASS_EN enables forwarding from the bypass stages; otherwise any bypass hit stalls.
module id_issue_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_BYP = 3,
  parameter int unsigned META_W  = 24
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_pc,
  input  logic [31:0]                 in_pred_pc,
  input  logic [31:0]                 in_imm,
  input  logic [5*NUM_SRC-1:0]        in_rs,
  input  logic [NUM_SRC-1:0]          in_rs_en,
  input  logic [4:0]                  in_rd,
  input  logic                        in_rd_we,
  input  logic [3:0]                  in_br_type,
  input  logic [META_W-1:0]           in_meta,
  input  logic [NUM_BYP-1:0]          byp_valid,
  input  logic [NUM_BYP-1:0]          byp_we,
  input  logic [NUM_BYP-1:0]          byp_data_ok,
  input  logic [5*NUM_BYP-1:0]        byp_addr,
  input  logic [DATA_W*NUM_BYP-1:0]   byp_data,
  input  logic                        wb_we,
  input  logic [4:0]                  wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output logic [31:0]                 out_imm,
  output logic [DATA_W*NUM_SRC-1:0]   out_src,
  output logic [4:0]                  out_rd,
  output logic                        out_rd_we,
  output logic [META_W-1:0]           out_meta,
  output logic                        redirect_valid,
  output logic [31:0]                 redirect_pc,
  output logic [31:0]                 stall_cnt
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned REG_N   = 32;
  localparam int unsigned SRC_PAD = (NUM_SRC > 1) ? NUM_SRC : 2;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLT  = 4'd3;
  localparam logic [3:0] BR_BGE  = 4'd4;
  localparam logic [3:0] BR_BLTU = 4'd5;
  localparam logic [3:0] BR_BGEU = 4'd6;
  localparam logic [3:0] BR_B    = 4'd7;
  localparam logic [3:0] BR_JIRL = 4'd8;

  typedef struct packed {
    logic [PC_W-1:0]         pc;
    logic [PC_W-1:0]         pred_pc;
    logic [PC_W-1:0]         imm;
    logic [RA_W*NUM_SRC-1:0] rs;
    logic [NUM_SRC-1:0]      rs_en;
    logic [RA_W-1:0]         rd;
    logic                    rd_we;
    logic [3:0]              br_type;
    logic [META_W-1:0]       meta;
  } instr_t;

  instr_t              h_q, h_d;
  logic                hv_q, hv_d;
  logic [DATA_W-1:0]   rf_q [REG_N];
  logic [DATA_W-1:0]   rf_d [REG_N];
  logic [31:0]         stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0]   src_val [SRC_PAD];
  logic [SRC_PAD-1:0]  src_rdy;
  logic [RA_W-1:0]     rs_s;
  logic                hit;
  logic [DATA_W-1:0]   rf_val;
  logic                go, fire, capture, taken;
  logic [PC_W-1:0]     tgt, next_pc;
`ifdef ID_BYPASS_EN
  logic                hit_ok;
  logic [DATA_W-1:0]   hit_data;
`else
  logic                unused_byp;
  assign unused_byp = ^{byp_data, byp_data_ok};
`endif

  // Per-source operand: nearest matching bypass stage wins, else write-through regfile.
  always_comb begin : operand_resolve
    for (int s = 0; s < SRC_PAD; s++) src_val[s] = '0;
    src_rdy = '1;
    rs_s    = '0;
    hit     = 1'b0;
    rf_val  = '0;
`ifdef ID_BYPASS_EN
    hit_ok   = 1'b0;
    hit_data = '0;
`endif
    for (int s = 0; s < NUM_SRC; s++) begin
      rs_s = h_q.rs[s*RA_W +: RA_W];
      if (h_q.rs_en[s] && (rs_s != '0)) begin
        hit = 1'b0;
`ifdef ID_BYPASS_EN
        hit_ok   = 1'b0;
        hit_data = '0;
`endif
        for (int b = 0; b < NUM_BYP; b++) begin
          if (!hit && byp_valid[b] && byp_we[b] && (byp_addr[b*RA_W +: RA_W] == rs_s)) begin
            hit = 1'b1;
`ifdef ID_BYPASS_EN
            hit_ok   = byp_data_ok[b];
            hit_data = byp_data[b*DATA_W +: DATA_W];
`endif
          end
        end
        rf_val = (wb_we && (wb_addr == rs_s)) ? wb_data : rf_q[rs_s];
`ifdef ID_BYPASS_EN
        src_rdy[s] = hit ? hit_ok : 1'b1;
        src_val[s] = hit ? hit_data : rf_val;
`else
        src_rdy[s] = !hit;
        src_val[s] = rf_val;
`endif
      end
    end
  end

  // Branch condition and resolved next PC of the held instruction.
  always_comb begin : branch_resolve
    taken = 1'b0;
    unique case (h_q.br_type)
      BR_BEQ:  taken = (src_val[0] == src_val[1]);
      BR_BNE:  taken = (src_val[0] != src_val[1]);
      BR_BLT:  taken = ($signed(src_val[0]) <  $signed(src_val[1]));
      BR_BGE:  taken = ($signed(src_val[0]) >= $signed(src_val[1]));
      BR_BLTU: taken = (src_val[0] <  src_val[1]);
      BR_BGEU: taken = (src_val[0] >= src_val[1]);
      BR_B, BR_JIRL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    tgt     = (h_q.br_type == BR_JIRL) ? (PC_W'(src_val[0]) + h_q.imm) : (h_q.pc + h_q.imm);
    next_pc = taken ? tgt : (h_q.pc + PC_W'(4));
  end

  assign go             = &src_rdy;
  assign out_valid      = hv_q && go && !flush;
  assign fire           = out_valid && out_ready;
  assign redirect_valid = fire && (h_q.br_type != BR_NONE) && (next_pc != h_q.pred_pc);
  assign redirect_pc    = next_pc;
  assign in_ready       = !hv_q || fire;
  assign capture        = in_valid && in_ready;

  assign out_pc    = h_q.pc;
  assign out_imm   = h_q.imm;
  assign out_rd    = h_q.rd;
  assign out_rd_we = h_q.rd_we;
  assign out_meta  = h_q.meta;
  assign stall_cnt = stall_cnt_q;

  always_comb begin : out_pack
    out_src = '0;
    for (int s = 0; s < NUM_SRC; s++) out_src[s*DATA_W +: DATA_W] = src_val[s];
  end

  // Holding-register, regfile and stall counter next state; flush beats redirect beats capture.
  always_comb begin : next_state
    hv_d = hv_q;
    if (flush)               hv_d = 1'b0;
    else if (redirect_valid) hv_d = 1'b0;
    else if (capture)        hv_d = 1'b1;
    else if (fire)           hv_d = 1'b0;

    h_d = h_q;
    if (capture) begin
      h_d.pc      = in_pc;
      h_d.pred_pc = in_pred_pc;
      h_d.imm     = in_imm;
      h_d.rs      = in_rs;
      h_d.rs_en   = in_rs_en;
      h_d.rd      = in_rd;
      h_d.rd_we   = in_rd_we;
      h_d.br_type = in_br_type;
      h_d.meta    = in_meta;
    end

    rf_d = rf_q;
    if (wb_we && (wb_addr != '0)) rf_d[wb_addr] = wb_data;

    stall_cnt_d = stall_cnt_q;
    if (hv_q && !go && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hv_q        <= 1'b0;
      h_q         <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
    end else begin
      hv_q        <= hv_d;
      h_q         <= h_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < REG_N; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule
